// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer: load/enable controls in,
// count and status flags out. clk and rest stay as plain module ports.
interface down_counter_timer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;
    logic             done;

    // Controller side: drives requests, observes the timer.
    modport master (
        output load, load_val, en, auto_reload,
        input  q, tc, busy, done
    );

    // Timer side.
    modport slave (
        input  load, load_val, en, auto_reload,
        output q, tc, busy, done
    );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down counter / interval timer. Counts a loaded value down to zero
// on enabled cycles, pulses tc for one cycle on reaching zero, and can
// optionally reload from the last loaded value and repeat.
module down_counter_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rest,
    down_counter_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rl_q, rl_d;
    logic             tc_q, tc_d;

    // Next-state: load beats counting; tc defaults low so it is a one-cycle pulse.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rl_d    = rl_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            q_d     = bus.load_val;
            rl_d    = bus.load_val;
            state_d = (bus.load_val != '0) ? S_RUN : S_IDLE;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (bus.en) begin
                        if (q_q == ONE) begin
                            q_d     = '0;
                            tc_d    = 1'b1;
                            state_d = S_EXPIRED;
                        end else if (q_q > ONE) begin
                            q_d = q_q - ONE;
                        end
                    end
                end
                S_EXPIRED: begin
                    if (bus.en && bus.auto_reload) begin
                        q_d     = rl_q;
                        state_d = S_RUN;
                    end
                end
                default: begin
                    // IDLE: hold, enable ignored
                end
            endcase
        end
    end

    // State registers with synchronous reset overriding every input.
    always_ff @(posedge clk) begin
        if (rest) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            rl_q    <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rl_q    <= rl_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.tc   = tc_q;
    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_EXPIRED);

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable, parameterised synchronous down counter: the count-down counterpart of the team's 4-bit up counter.
- Counts from a loaded value to zero on enabled cycles, then flags terminal count. Optionally reloads and repeats.
- Used as an interval/timeout timer beside the up counter in the same clock domain. Output count is directly observable for display or debug.

Parameters:
- WIDTH, 4, bit width of count, load value and reload register (min 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rest  input  1  synchronous, active-high reset; sampled on rising clk; overrides every other input.
- load  input  1  load request. Copies load_val into q and the reload register on the next edge.
- load_val  input  WIDTH  value captured when load=1.
- en  input  1  count enable. When 0, state, q and the reload register hold (tc still clears).
- auto_reload  input  1  when 1, an expired timer reloads from the reload register on the next enabled cycle.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse, registered. High for exactly one cycle, in the cycle q first reads 0 after counting down.
- busy  output  1  high while in RUN.
- done  output  1  high while in EXPIRED.

Behaviour:
- Reset (rest=1 at edge): q=0, reload register rl=0, state=IDLE, tc=0, busy=0, done=0. This applies regardless of load/en, including mid-count.
- States: IDLE, RUN, EXPIRED. busy = (state==RUN), done = (state==EXPIRED), both decoded from registered state. tc is its own flop.
- Priority per edge: rest > load > en-driven counting.
- load=1:
  - q<=load_val, rl<=load_val, tc<=0.
  - Next state is RUN if load_val!=0; otherwise IDLE.
  - Allowed in any state. Restarts a running count without a tc.
- IDLE: q holds; en ignored; tc<=0.
- RUN, en=1, q>1: q<=q-1, tc<=0.
- RUN, en=1, q==1: q<=0, tc<=1, state<=EXPIRED.
- RUN, en=0: q and state hold, tc<=0.
- EXPIRED:
  - tc<=0 on every edge (guarantees a one-cycle pulse).
  - If en=1 and auto_reload=1: q<=rl, state<=RUN. rl!=0 is guaranteed, because EXPIRED is reachable only from RUN.
  - Otherwise q stays 0 and state holds until load or rest.
- auto_reload is sampled only in EXPIRED; changing it during RUN has no effect until expiry.
- Latency: loading N (N>=1) with en held high gives tc=1 and q=0 exactly N edges after the load edge.
- Auto-reload period with en held high: N+1 cycles per tc (N count cycles plus one EXPIRED cycle).
- q never wraps below 0. Decrement occurs only in RUN with q>=1. WIDTH-bit arithmetic, no carry out.
- Load with all-ones (2^WIDTH-1) counts the full range. No overflow is possible.
- load on the same edge that would have produced tc: load wins, and no tc is emitted.

Test Plan:
- Basic count: WIDTH=4, rest, then load=1 load_val=5, en=1 held -> q sequence 5,4,3,2,1,0; tc=1 only on the q=0 cycle; busy=1 during 5..1; done=1 from q=0 onward; q stays 0 with auto_reload=0.
- Enable gating: load 3, toggle en 1,0,0,1,1 -> q: 3,2,2,2,1,0; tc high once, on the 0 cycle; busy held through the en=0 cycles.
- Auto-reload: load 2, auto_reload=1, en=1 for 9 cycles -> q: 2,1,0,2,1,0,2,1,0; tc pulses every 3 cycles; done and busy alternate as specified.
- Load-zero and override: load 0 -> state IDLE, q=0, tc=0, busy=0, done=0. Then load 4, and when q==1 assert load with load_val=7 alongside en -> q=7 next cycle, no tc.
- Reset mid-operation: load 15, count to q=9, assert rest with load=1 and en=1 simultaneously -> next cycle q=0, tc=0, busy=0, done=0. Subsequent en cycles leave q at 0 (IDLE).
- Full range: load 15, en=1 -> tc exactly 15 edges after the load edge, q reaches 0 without wrapping to 15.
